// File: rtl/vx_strobe_elastic_pkg.sv
// Shared constants and helpers for the strobe-to-stream elastic return buffer.
package vx_strobe_elastic_pkg;

    localparam int unsigned DROP_CNT_W = 8;

    // Width needed to hold an occupancy value in the range 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vx_strobe_elastic_if.sv
// Producer strobe / consumer stream bundle for vx_strobe_elastic.
// master = surrounding logic (producer + consumer), slave = the elastic buffer.
interface vx_strobe_elastic_if
    import vx_strobe_elastic_pkg::*;
#(
    parameter int unsigned DATAW = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic                  strobe;
    logic [DATAW-1:0]      data_in;
    logic                  busy;
    logic                  valid_out;
    logic [DATAW-1:0]      data_out;
    logic                  ready_out;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_count;

    modport master (
        output strobe, data_in, ready_out,
        input  busy, valid_out, data_out, count, overflow, drop_count
    );

    modport slave (
        input  strobe, data_in, ready_out,
        output busy, valid_out, data_out, count, overflow, drop_count
    );

endinterface

// File: rtl/vx_strobe_elastic_mem.sv
// DEPTH x DATAW register array: one synchronous write port, one asynchronous read port.
module vx_strobe_elastic_mem #(
    parameter int unsigned DATAW = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATAW-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATAW-1:0]         rdata
);

    logic [DATAW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vx_strobe_elastic.sv
// Turns one-cycle result strobes into a valid/ready stream through a DEPTH-entry FIFO.
// Optional STROBE_ELASTIC_OVF_EN: sticky overflow flag, saturating drop counter, drop assertion.
module vx_strobe_elastic
    import vx_strobe_elastic_pkg::*;
#(
    parameter int unsigned DATAW       = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned BUSY_MARGIN = 1
) (
    input  logic               clk,
    input  logic               reset,
    vx_strobe_elastic_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             pop;
    logic             push;

    assign pop  = (count_q != '0) && bus.ready_out;
    // A full buffer still accepts a strobe when the head leaves in the same cycle.
    assign push = bus.strobe && ((count_q < CNT_W'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    vx_strobe_elastic_mem #(
        .DATAW (DATAW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (bus.data_out)
    );

    assign bus.count     = count_q;
    assign bus.valid_out = (count_q != '0);
    assign bus.busy      = (count_q >= CNT_W'(DEPTH - BUSY_MARGIN));

`ifdef STROBE_ELASTIC_OVF_EN
    logic                  drop;
    logic                  ovf_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    assign drop = bus.strobe && (count_q == CNT_W'(DEPTH)) && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!drop) else $error("vx_strobe_elastic: strobe dropped while buffer full");
        end
    end

    assign bus.overflow   = ovf_q;
    assign bus.drop_count = drop_cnt_q;
`else
    assign bus.overflow   = 1'b0;
    assign bus.drop_count = '0;
`endif

endmodule

// File: tb/tb_vx_strobe_elastic.sv
// Directed and scoreboarded checks for vx_strobe_elastic (DEPTH=4, BUSY_MARGIN=1).
module tb_vx_strobe_elastic;

    localparam int unsigned DATAW = 32;
    localparam int unsigned DEPTH = 4;

`ifdef STROBE_ELASTIC_OVF_EN
    localparam logic [31:0] EXP_OVF_1   = 32'd1;
    localparam logic [31:0] EXP_DROP_1  = 32'd1;
    localparam logic [31:0] EXP_DROP_SAT = 32'd255;
`else
    localparam logic [31:0] EXP_OVF_1   = 32'd0;
    localparam logic [31:0] EXP_DROP_1  = 32'd0;
    localparam logic [31:0] EXP_DROP_SAT = 32'd0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    vx_strobe_elastic_if #(.DATAW(DATAW), .DEPTH(DEPTH)) bus ();

    vx_strobe_elastic #(
        .DATAW       (DATAW),
        .DEPTH       (DEPTH),
        .BUSY_MARGIN (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs, clock once, then settle 1ns past the edge.
    task automatic step(input logic s, input logic [31:0] d, input logic r);
        bus.strobe    = s;
        bus.data_in   = d;
        bus.ready_out = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int cnt, input logic vld, input logic bsy);
        check({tag, ".count"}, 32'(bus.count), 32'(cnt));
        check({tag, ".valid"}, 32'(bus.valid_out), 32'(vld));
        check({tag, ".busy"},  32'(bus.busy), 32'(bsy));
    endtask

    logic [31:0] sb[$];
    logic [31:0] exp_head;
    logic        s_r;
    logic        r_r;
    logic        pop_m;

    initial begin
        reset = 1'b1;
        step(1'b1, 32'hDEAD_0000, 1'b0);   // strobe during reset must be ignored
        step(1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        check_state("reset", 0, 1'b0, 1'b0);
        check("reset.ovf",  32'(bus.overflow), 32'd0);
        check("reset.drop", 32'(bus.drop_count), 32'd0);

        // A, B, C with consumer stalled; A must not appear in its own cycle
        bus.strobe = 1'b1; bus.data_in = 32'hA; bus.ready_out = 1'b0;
        #1;
        check("a.same_cycle_valid", 32'(bus.valid_out), 32'd0);
        step(1'b1, 32'hA, 1'b0);
        check_state("a", 1, 1'b1, 1'b0);
        check("a.head", bus.data_out, 32'hA);
        step(1'b1, 32'hB, 1'b0);
        check_state("b", 2, 1'b1, 1'b0);
        step(1'b1, 32'hC, 1'b0);
        check_state("c", 3, 1'b1, 1'b1);
        check("c.head", bus.data_out, 32'hA);

        // D fills, E is dropped
        step(1'b1, 32'hD, 1'b0);
        check_state("d", 4, 1'b1, 1'b1);
        step(1'b1, 32'hE, 1'b0);
        check_state("e", 4, 1'b1, 1'b1);
        check("e.head", bus.data_out, 32'hA);
        check("e.ovf",  32'(bus.overflow), EXP_OVF_1);
        check("e.drop", 32'(bus.drop_count), EXP_DROP_1);

        // Full + pop + strobe: F accepted, A popped
        step(1'b1, 32'hF, 1'b1);
        check_state("f", 4, 1'b1, 1'b1);
        check("f.head", bus.data_out, 32'hB);
        step(1'b0, 32'h0, 1'b1);
        check("drain.c", bus.data_out, 32'hC);
        check("drain.c.count", 32'(bus.count), 32'd3);
        step(1'b0, 32'h0, 1'b1);
        check("drain.d", bus.data_out, 32'hD);
        step(1'b0, 32'h0, 1'b1);
        check("drain.f", bus.data_out, 32'hF);
        check_state("drain.f", 1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        check_state("drained", 0, 1'b0, 1'b0);

        // Empty + strobe + ready: no bypass
        bus.strobe = 1'b1; bus.data_in = 32'h6; bus.ready_out = 1'b1;
        #1;
        check("g.same_cycle_valid", 32'(bus.valid_out), 32'd0);
        step(1'b1, 32'h6, 1'b1);
        check_state("g", 1, 1'b1, 1'b0);
        check("g.head", bus.data_out, 32'h6);
        step(1'b0, 32'h0, 1'b1);
        check_state("g.popped", 0, 1'b0, 1'b0);

        // Simultaneous push and pop at mid occupancy
        step(1'b1, 32'h11, 1'b0);
        step(1'b1, 32'h12, 1'b0);
        step(1'b1, 32'h13, 1'b1);
        check("pp.count", 32'(bus.count), 32'd2);
        check("pp.head",  bus.data_out, 32'h12);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check_state("pp.drained", 0, 1'b0, 1'b0);

        // Fill and hammer with 300 dropped strobes
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 32'hBAD, 1'b0);
        check_state("sat", 4, 1'b1, 1'b1);
        check("sat.head", bus.data_out, 32'h100);
        check("sat.ovf",  32'(bus.overflow), EXP_OVF_1);
        check("sat.drop", 32'(bus.drop_count), EXP_DROP_SAT);

        // Reset with three entries buffered
        step(1'b0, 32'h0, 1'b1);
        check_state("pre_rst", 3, 1'b1, 1'b1);
        check("pre_rst.head", bus.data_out, 32'h101);
        reset = 1'b1;
        step(1'b1, 32'h77, 1'b0);
        reset = 1'b0;
        check_state("mid_rst", 0, 1'b0, 1'b0);
        check("mid_rst.ovf",  32'(bus.overflow), 32'd0);
        check("mid_rst.drop", 32'(bus.drop_count), 32'd0);

        // Random traffic with a producer that respects busy
        for (int cyc = 0; cyc < 10000; cyc++) begin
            s_r = !bus.busy && ($urandom_range(0, 1) == 1);
            r_r = ($urandom_range(0, 2) != 0);
            bus.strobe    = s_r;
            bus.data_in   = $urandom;
            bus.ready_out = r_r;
            #1;
            pop_m = (sb.size() != 0) && r_r;
            if (pop_m) begin
                exp_head = sb.pop_front();
                check("rnd.data", bus.data_out, exp_head);
            end
            if (s_r && (sb.size() < DEPTH)) sb.push_back(bus.data_in);
            @(posedge clk);
            #1;
            check("rnd.count", 32'(bus.count), 32'(sb.size()));
        end
        check("rnd.ovf", 32'(bus.overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
